// File: rtl/addsub_rr_scheduler_if.sv
// Request/response bundle for addsub_rr_scheduler. The rsp_ovf field exists only
// when ADDSUB_SCHED_OVF_EN is defined.
interface addsub_rr_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [4*NUM_REQ-1:0] req_a;
  logic [4*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]   req_op;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [3:0]           rsp_data;
  logic                 rsp_cout;
  logic [ID_W-1:0]      rsp_id;
  logic                 busy;
`ifdef ADDSUB_SCHED_OVF_EN
  logic                 rsp_ovf;

  // Requesters and the response consumer drive the master side.
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_cout, rsp_id, busy, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_cout, rsp_id, busy, rsp_ovf
  );
`else
  // Requesters and the response consumer drive the master side.
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_cout, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_cout, rsp_id, busy
  );
`endif
endinterface

// File: rtl/addsub_rr_scheduler.sv
// Round-robin scheduler sharing one 4-bit adder/subtractor among NUM_REQ requesters.
// Optional macro ADDSUB_SCHED_OVF_EN adds a registered signed-overflow flag (rsp_ovf).
module addsub_rr_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  addsub_rr_scheduler_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]      r_state;
  logic [ID_W-1:0] r_ptr;
  logic [3:0]      r_a;
  logic [3:0]      r_b;
  logic            r_op;
  logic [ID_W-1:0] r_id;
  logic            r_rsp_valid;
  logic [3:0]      r_rsp_data;
  logic            r_rsp_cout;
  logic [ID_W-1:0] r_rsp_id;

  logic [3:0]      w_a_sl [NUM_REQ];
  logic [3:0]      w_b_sl [NUM_REQ];
  logic            w_grant_found;
  logic [ID_W-1:0] w_grant_id;
  logic            w_grant_en;
  logic [NUM_REQ-1:0] w_req_ready;
  logic [3:0]      w_b_eff;
  logic [4:0]      w_sum;
  logic [ID_W-1:0] w_ptr_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_a_sl[gi]      = bus.req_a[4*gi +: 4];
      assign w_b_sl[gi]      = bus.req_b[4*gi +: 4];
      assign w_req_ready[gi] = w_grant_en && (w_grant_id == ID_W'(gi));
    end
  endgenerate

  // Circular search from r_ptr: walk offsets high to low so the smallest offset wins.
  always_comb begin
    int cand_i;
    cand_i        = 0;
    w_grant_found = 1'b0;
    w_grant_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_i = int'(r_ptr) + k;
      if (cand_i >= NUM_REQ) begin
        cand_i = cand_i - NUM_REQ;
      end
      if (bus.req_valid[ID_W'(cand_i)]) begin
        w_grant_found = 1'b1;
        w_grant_id    = ID_W'(cand_i);
      end
    end
  end

  assign w_grant_en = (r_state == ST_IDLE) && !rst && w_grant_found;

  // Subtract is A + ~B + 1, so the carry out reads as "no borrow".
  assign w_b_eff = r_b ^ {4{r_op}};
  assign w_sum   = {1'b0, r_a} + {1'b0, w_b_eff} + {4'b0000, r_op};

  assign w_ptr_next = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 1'b0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_cout  <= 1'b0;
      r_rsp_id    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_en) begin
            r_a     <= w_a_sl[w_grant_id];
            r_b     <= w_b_sl[w_grant_id];
            r_op    <= bus.req_op[w_grant_id];
            r_id    <= w_grant_id;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_data  <= w_sum[3:0];
          r_rsp_cout  <= w_sum[4];
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          // Pointer moves only on a completed handshake so a stall never skips a turn.
          if (r_rsp_valid && bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= w_ptr_next;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ADDSUB_SCHED_OVF_EN
  logic r_rsp_ovf;
  logic w_ovf;

  // Overflow of the effective operation: operands agree in sign after B is
  // conditionally inverted, yet the result sign differs from A.
  assign w_ovf = r_op ? ((r_a[3] != r_b[3]) && (w_sum[3] != r_a[3]))
                      : ((r_a[3] == r_b[3]) && (w_sum[3] != r_a[3]));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_ovf <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_rsp_ovf <= w_ovf;
    end
  end

  assign bus.rsp_ovf = r_rsp_ovf;
`endif

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_cout  = r_rsp_cout;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule
